// File: rtl/mem_dump_sequencer_pkg.sv
// Shared definitions for the memory-dump sequencer and the data-cache wrapper.
// Holds the sequencer state encoding, the captured-word record and the
// default read latency that both sides of the cache port must agree on.
package mem_dump_sequencer_pkg;

    // Sequencer states; the encodings are fixed so that debug probes and the
    // cache wrapper can decode them.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        PRESENT = 3'd3,
        DONE    = 3'd4
    } state_e;

    // Default cycles from a stable fpga_address to a valid fpga_value.
    // The data-cache wrapper uses this same constant for its read pipeline.
    localparam int unsigned DEFAULT_READ_LATENCY = 2;

    // Default dump geometry: word-addressed cache, first eight words.
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd0;
    localparam int unsigned DEFAULT_NUM_WORDS = 8;
    localparam logic [31:0] DEFAULT_ADDR_STEP = 32'd1;

    // One captured word together with its position in the dump.
    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  index;
    } dump_word_t;

    // Width of the read-latency down-counter. It only has to hold
    // latency-1, so a latency of 1 or 2 needs a single bit.
    function automatic int wait_cnt_width(input int unsigned latency);
        return (latency < 2) ? 1 : int'($clog2(latency));
    endfunction

endpackage

// File: rtl/mem_dump_sequencer_rise_detect.sv
// rise_detect: registered rising-edge detector for a single level input.
// The output pulses for one cycle, one clock after the input is first seen
// high. The history flop clears on reset, so an input that is already high
// when reset is released is reported as a rise.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;
    logic prev_d;
    logic rise_q;
    logic rise_d;

    // Next state: remember the input, flag a 0->1 transition.
    always_comb begin
        prev_d = sig_i;
        rise_d = sig_i & ~prev_q;
    end

    // History and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/mem_dump_sequencer.sv
// mem_dump_sequencer: once the core halts (program_done), take over the
// data-cache address port, read NUM_WORDS consecutive words and hand each one
// to a readout consumer over a valid/ready handshake. Ownership of the port
// (address_mode) is released when the dump completes or program_done drops.
module mem_dump_sequencer
    import mem_dump_sequencer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
    parameter int unsigned NUM_WORDS    = DEFAULT_NUM_WORDS,
    parameter logic [31:0] ADDR_STEP    = DEFAULT_ADDR_STEP,
    parameter int unsigned READ_LATENCY = DEFAULT_READ_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        program_done,
    input  logic        dump_req,
    input  logic [31:0] fpga_value,
    input  logic        word_ready,
    output logic        address_mode,
    output logic [31:0] fpga_address,
    output logic [31:0] word_data,
    output logic [7:0]  word_index,
    output logic        word_valid,
    output logic        dump_done
);

    localparam int                CNT_W      = wait_cnt_width(READ_LATENCY);
    localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(READ_LATENCY - 1);
    localparam logic [7:0]        LAST_INDEX = 8'(NUM_WORDS - 1);

    // Sequencer state and bookkeeping.
    state_e            state_q,        state_d;
    logic [7:0]        index_q,        index_d;
    logic [CNT_W-1:0]  wait_cnt_q,     wait_cnt_d;

    // Registered outputs.
    logic              address_mode_q, address_mode_d;
    logic [31:0]       fpga_address_q, fpga_address_d;
    dump_word_t        word_q,         word_d;
    logic              word_valid_q,   word_valid_d;
    logic              dump_done_q,    dump_done_d;

    // One-cycle pulse, one clock after program_done is first seen high.
    logic program_rise;
    // Begin a fresh dump from word 0 this cycle.
    logic launch;

    rise_detect u_rise_detect (
        .clk    (clk),
        .rst_n  (reset),
        .sig_i  (program_done),
        .rise_o (program_rise)
    );

    // Next-state and next-output logic for the dump sequencer.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d        = state_q;
        index_d        = index_q;
        wait_cnt_d     = wait_cnt_q;
        address_mode_d = address_mode_q;
        fpga_address_d = fpga_address_q;
        word_d         = word_q;
        word_valid_d   = word_valid_q;
        dump_done_d    = dump_done_q;
        launch         = 1'b0;

        case (state_q)
            IDLE: begin
                // A rise and a dump_req in the same cycle are one start; the
                // later rise pulse lands in ISSUE and is ignored there.
                launch = program_done && (program_rise || dump_req);
            end

            ISSUE: begin
                // Address has been driven since entry; start the latency count.
                wait_cnt_d = CNT_LOAD;
                state_d    = WAIT;
            end

            WAIT: begin
                if (wait_cnt_q == '0) begin
                    word_d.data  = fpga_value;
                    word_d.index = index_q;
                    word_valid_d = 1'b1;
                    state_d      = PRESENT;
                end else begin
                    wait_cnt_d = wait_cnt_q - CNT_W'(1);
                end
            end

            PRESENT: begin
                // word_valid is high throughout PRESENT, so ready alone
                // completes the handshake; ready in other states is ignored.
                if (word_ready) begin
                    word_valid_d = 1'b0;
                    if (index_q == LAST_INDEX) begin
                        address_mode_d = 1'b0;
                        fpga_address_d = '0;
                        dump_done_d    = 1'b1;
                        state_d        = DONE;
                    end else begin
                        // Incremental step equals BASE_ADDR + index*ADDR_STEP
                        // modulo 2^32, without a multiplier.
                        index_d        = index_q + 8'd1;
                        fpga_address_d = fpga_address_q + ADDR_STEP;
                        state_d        = ISSUE;
                    end
                end
            end

            DONE: begin
                launch = program_done && dump_req;
            end

            default: begin
                // Unreachable encodings fall back to a clean idle.
                address_mode_d = 1'b0;
                fpga_address_d = '0;
                word_valid_d   = 1'b0;
                dump_done_d    = 1'b0;
                state_d        = IDLE;
            end
        endcase

        // Start of a dump: claim the address port and point at word 0.
        if (launch) begin
            index_d        = '0;
            address_mode_d = 1'b1;
            fpga_address_d = BASE_ADDR;
            word_valid_d   = 1'b0;
            dump_done_d    = 1'b0;
            state_d        = ISSUE;
        end

        // Abort wins over the handshake and over dump_req: if the core is no
        // longer halted, hand the address port straight back.
        if (state_q != IDLE && !program_done) begin
            address_mode_d = 1'b0;
            fpga_address_d = '0;
            word_valid_d   = 1'b0;
            dump_done_d    = 1'b0;
            state_d        = IDLE;
        end
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            index_q        <= '0;
            wait_cnt_q     <= '0;
            address_mode_q <= 1'b0;
            fpga_address_q <= '0;
            word_q         <= '0;
            word_valid_q   <= 1'b0;
            dump_done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q        <= state_d;
            index_q        <= index_d;
            wait_cnt_q     <= wait_cnt_d;
            address_mode_q <= address_mode_d;
            fpga_address_q <= fpga_address_d;
            word_q         <= word_d;
            word_valid_q   <= word_valid_d;
            dump_done_q    <= dump_done_d;
        end
    end

    assign address_mode = address_mode_q;
    assign fpga_address = fpga_address_q;
    assign word_data    = word_q.data;
    assign word_index   = word_q.index;
    assign word_valid   = word_valid_q;
    assign dump_done    = dump_done_q;

endmodule
